// File: rtl/axis_pkt_pkg.sv
// axis_pkt_gen shared types: FSM encoding, default widths, LFSR taps.
// Optional build macro: AXIS_PKT_GEN_LFSR_EN (LFSR payload).
package axis_pkt_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } state_t;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_LEN_W  = 8;
  localparam int DEF_CNT_W  = 8;
  localparam int DEF_GAP_W  = 4;

  // Fibonacci taps 8,6,5,4 as a bit mask
  localparam logic [7:0] LFSR_TAPS8 = 8'hB8;

  function automatic logic [31:0] lfsr_taps(input int w);
    case (w)
      16:      return 32'h0000_B400;
      32:      return 32'h8020_0003;
      default: return 32'(LFSR_TAPS8);
    endcase
  endfunction

endpackage

// File: rtl/axis_pkt_payload.sv
// Payload register: seed load, then advance once per accepted beat.
// AXIS_PKT_GEN_LFSR_EN selects an LFSR instead of the incrementer.
module axis_pkt_payload
  import axis_pkt_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_W
) (
  input  logic                  aclk,
  input  logic                  areset,
  input  logic                  load,
  input  logic                  en,
  input  logic [DATA_WIDTH-1:0] seed,
  output logic [DATA_WIDTH-1:0] data
);

  logic [DATA_WIDTH-1:0] seed_v;
  logic [DATA_WIDTH-1:0] next_v;

`ifdef AXIS_PKT_GEN_LFSR_EN
  localparam logic [DATA_WIDTH-1:0] TAPS =
    DATA_WIDTH'(lfsr_taps(DATA_WIDTH));

  // all-zero state would lock the LFSR
  assign seed_v = (seed == '0) ? DATA_WIDTH'(1) : seed;
  assign next_v = {data[DATA_WIDTH-2:0], ^(data & TAPS)};
`else
  assign seed_v = seed;
  assign next_v = data + 1'b1;
`endif

  always_ff @(posedge aclk) begin
    if (areset) begin
      data <= '0;
    end else if (load) begin
      data <= seed_v;
    end else if (en) begin
      data <= next_v;
    end
  end

endmodule

// File: rtl/axis_pkt_gen.sv
// AXI4-Stream burst packet generator (master side).
// Build option AXIS_PKT_GEN_LFSR_EN switches payload to an LFSR.
module axis_pkt_gen
  import axis_pkt_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_W,
  parameter int LEN_W      = DEF_LEN_W,
  parameter int CNT_W      = DEF_CNT_W,
  parameter int GAP_W      = DEF_GAP_W
) (
  input  logic                  aclk,
  input  logic                  areset,
  input  logic                  start,
  input  logic [LEN_W-1:0]      cfg_len,
  input  logic [CNT_W-1:0]      cfg_num,
  input  logic [GAP_W-1:0]      cfg_gap,
  input  logic [DATA_WIDTH-1:0] cfg_seed,
  output logic                  busy,
  output logic                  done,
  output logic [CNT_W-1:0]      pkt_count,
  output logic [DATA_WIDTH-1:0] m_tdata,
  output logic                  m_tvalid,
  input  logic                  m_tready,
  output logic                  m_tlast
);

  state_t           state;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] beat;
  logic [CNT_W-1:0] num_q;
  logic [GAP_W-1:0] gap_q;
  logic [GAP_W-1:0] gap_cnt;

  logic accept;
  logic load;
  logic last_pkt;

  assign accept   = m_tvalid & m_tready;
  assign load     = (state == IDLE) & start;
  assign last_pkt = (pkt_count == num_q - 1'b1);

  axis_pkt_payload #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_payload (
    .aclk  (aclk),
    .areset(areset),
    .load  (load),
    .en    (accept),
    .seed  (cfg_seed),
    .data  (m_tdata)
  );

  always_ff @(posedge aclk) begin
    if (areset) begin
      state     <= IDLE;
      m_tvalid  <= 1'b0;
      m_tlast   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pkt_count <= '0;
      len_q     <= '0;
      num_q     <= '0;
      gap_q     <= '0;
      gap_cnt   <= '0;
      beat      <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            len_q <= cfg_len;
            num_q <= cfg_num;
            gap_q <= cfg_gap;
            beat  <= '0;
            if (cfg_num == '0) begin
              done <= 1'b1;
            end else begin
              state     <= SEND;
              busy      <= 1'b1;
              m_tvalid  <= 1'b1;
              m_tlast   <= (cfg_len == '0);
              pkt_count <= '0;
            end
          end
        end
        SEND: begin
          if (accept) begin
            if (m_tlast) begin
              pkt_count <= pkt_count + 1'b1;
              beat      <= '0;
              if (last_pkt) begin
                state    <= IDLE;
                busy     <= 1'b0;
                done     <= 1'b1;
                m_tvalid <= 1'b0;
                m_tlast  <= 1'b0;
              end else if (gap_q != '0) begin
                state    <= GAP;
                gap_cnt  <= gap_q - 1'b1;
                m_tvalid <= 1'b0;
                m_tlast  <= 1'b0;
              end else begin
                m_tlast <= (len_q == '0);
              end
            end else begin
              beat    <= beat + 1'b1;
              m_tlast <= (beat + 1'b1 == len_q);
            end
          end
        end
        GAP: begin
          if (gap_cnt == '0) begin
            state    <= SEND;
            m_tvalid <= 1'b1;
            m_tlast  <= (len_q == '0);
          end else begin
            gap_cnt <= gap_cnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axis_pkt_gen.sv
// Self-checking bench for axis_pkt_gen against a beat-list model.
// Honours AXIS_PKT_GEN_LFSR_EN for the expected payload.
module tb_axis_pkt_gen;

  logic       aclk = 1'b0;
  logic       areset;
  logic       start;
  logic [7:0] cfg_len;
  logic [7:0] cfg_num;
  logic [3:0] cfg_gap;
  logic [7:0] cfg_seed;
  logic       busy;
  logic       done;
  logic [7:0] pkt_count;
  logic [7:0] m_tdata;
  logic       m_tvalid;
  logic       m_tready;
  logic       m_tlast;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 aclk = ~aclk;

  axis_pkt_gen dut (
    .aclk     (aclk),
    .areset   (areset),
    .start    (start),
    .cfg_len  (cfg_len),
    .cfg_num  (cfg_num),
    .cfg_gap  (cfg_gap),
    .cfg_seed (cfg_seed),
    .busy     (busy),
    .done     (done),
    .pkt_count(pkt_count),
    .m_tdata  (m_tdata),
    .m_tvalid (m_tvalid),
    .m_tready (m_tready),
    .m_tlast  (m_tlast)
  );

  function automatic logic [7:0] first_pay(input logic [7:0] s);
`ifdef AXIS_PKT_GEN_LFSR_EN
    return (s == 8'd0) ? 8'd1 : s;
`else
    return s;
`endif
  endfunction

  function automatic logic [7:0] next_pay(input logic [7:0] d);
`ifdef AXIS_PKT_GEN_LFSR_EN
    return {d[6:0], d[7] ^ d[5] ^ d[4] ^ d[3]};
`else
    return d + 8'd1;
`endif
  endfunction

  task automatic run_burst(input string tag, input int len, input int num,
                           input int gap, input logic [7:0] seed,
                           input int rmode, input bit now);
    logic [7:0] ed[$];
    bit         el[$];
    logic [7:0] d;
    logic [7:0] pd;
    logic       pl;
    int idx = 0, idle = 0, cyc = 0, pkts = 0;
    bit watch = 0, stall = 0, fin = 0, cnt_chk = 0;
    d = first_pay(seed);
    for (int p = 0; p < num; p++) begin
      for (int b = 0; b <= len; b++) begin
        ed.push_back(d);
        el.push_back(b == len);
        d = next_pay(d);
      end
    end
    if (!now) @(negedge aclk);
    cfg_len  = 8'(len);
    cfg_num  = 8'(num);
    cfg_gap  = 4'(gap);
    cfg_seed = seed;
    start    = 1'b1;
    m_tready = 1'b1;
    @(negedge aclk);
    start    = 1'b0;
    cfg_len  = 8'($urandom);
    cfg_num  = 8'($urandom);
    cfg_gap  = 4'($urandom);
    cfg_seed = 8'($urandom);
    if (num == 0) begin
      n_chk++;
      if (done !== 1'b1 || busy !== 1'b0 || m_tvalid !== 1'b0) begin
        n_fail++;
        $display("FAIL %s zero_num: done=%b busy=%b valid=%b want 1 0 0",
                 tag, done, busy, m_tvalid);
      end
      repeat (4) begin
        @(negedge aclk);
        n_chk++;
        if (done !== 1'b0 || m_tvalid !== 1'b0) begin
          n_fail++;
          $display("FAIL %s zero_num_after: done=%b valid=%b want 0 0",
                   tag, done, m_tvalid);
        end
      end
      return;
    end
    n_chk++;
    if (m_tvalid !== 1'b1 || busy !== 1'b1 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL %s latency: valid=%b busy=%b done=%b want 1 1 0",
               tag, m_tvalid, busy, done);
    end
    while (!fin && cyc < 4000) begin
      if (rmode == 0) m_tready = 1'b1;
      else if (rmode == 1) m_tready = (cyc % 3 == 0);
      else m_tready = 1'($urandom_range(0, 1));
      if (cnt_chk) begin
        n_chk++;
        if (pkt_count !== 8'(pkts)) begin
          n_fail++;
          $display("FAIL %s pkt_count: got %0d want %0d", tag, pkt_count, pkts);
        end
        cnt_chk = 0;
      end
      if (stall) begin
        n_chk++;
        if (m_tvalid !== 1'b1 || m_tdata !== pd || m_tlast !== pl) begin
          n_fail++;
          $display("FAIL %s stable: got v=%b d=%h l=%b want v=1 d=%h l=%b",
                   tag, m_tvalid, m_tdata, m_tlast, pd, pl);
        end
      end
      if (watch && m_tvalid) begin
        n_chk++;
        if (idle != gap) begin
          n_fail++;
          $display("FAIL %s gap: got %0d idle want %0d", tag, idle, gap);
        end
        watch = 0;
      end else if (watch) begin
        idle++;
      end else begin
        n_chk++;
        if (m_tvalid !== 1'b1) begin
          n_fail++;
          $display("FAIL %s valid_hold: got %b want 1 (beat %0d)",
                   tag, m_tvalid, idx);
        end
      end
      if (m_tvalid && m_tready) begin
        n_chk++;
        if (m_tdata !== ed[idx] || m_tlast !== el[idx]) begin
          n_fail++;
          $display("FAIL %s beat%0d: got d=%h l=%b want d=%h l=%b",
                   tag, idx, m_tdata, m_tlast, ed[idx], el[idx]);
        end
        if (el[idx]) begin
          pkts++;
          cnt_chk = 1;
          if (idx + 1 < ed.size()) begin
            watch = 1;
            idle  = 0;
          end
        end
        idx++;
        if (idx == ed.size()) fin = 1;
      end
      stall = m_tvalid & ~m_tready;
      pd    = m_tdata;
      pl    = m_tlast;
      @(negedge aclk);
      cyc++;
    end
    n_chk++;
    if (!fin) begin
      n_fail++;
      $display("FAIL %s timeout: got %0d beats want %0d", tag, idx, ed.size());
    end else if (done !== 1'b1 || busy !== 1'b0 || m_tvalid !== 1'b0 ||
                 pkt_count !== 8'(num)) begin
      n_fail++;
      $display("FAIL %s end: done=%b busy=%b valid=%b cnt=%0d want 1 0 0 %0d",
               tag, done, busy, m_tvalid, pkt_count, num);
    end
  endtask

  task automatic test_reset();
    areset   = 1'b1;
    start    = 1'b0;
    m_tready = 1'b0;
    cfg_len  = '0;
    cfg_num  = '0;
    cfg_gap  = '0;
    cfg_seed = '0;
    repeat (3) @(negedge aclk);
    n_chk++;
    if ({m_tvalid, m_tlast, busy, done} !== 4'b0 || m_tdata !== 8'h00 ||
        pkt_count !== 8'h00) begin
      n_fail++;
      $display("FAIL reset: v=%b l=%b b=%b d=%b data=%h cnt=%0d want all 0",
               m_tvalid, m_tlast, busy, done, m_tdata, pkt_count);
    end
    areset = 1'b0;
  endtask

  task automatic test_single_packet();
    run_burst("single", 3, 1, 0, 8'h10, 0, 0);
  endtask

  task automatic test_backpressure();
    run_burst("bp", 3, 1, 0, 8'h10, 1, 0);
  endtask

  task automatic test_gap_wrap();
    run_burst("gap", 1, 3, 2, 8'hFE, 0, 0);
  endtask

  task automatic test_single_beat();
    run_burst("len0", 0, 4, 0, 8'h33, 0, 0);
  endtask

  task automatic test_reset_mid();
    logic [7:0] e;
    e = next_pay(next_pay(first_pay(8'h40)));
    @(negedge aclk);
    cfg_len  = 8'd3;
    cfg_num  = 8'd1;
    cfg_gap  = 4'd0;
    cfg_seed = 8'h40;
    start    = 1'b1;
    m_tready = 1'b1;
    @(negedge aclk);
    start = 1'b0;
    repeat (2) @(negedge aclk);
    n_chk++;
    if (m_tvalid !== 1'b1 || m_tdata !== e) begin
      n_fail++;
      $display("FAIL rst_mid beat2: v=%b d=%h want 1 %h", m_tvalid, m_tdata, e);
    end
    areset = 1'b1;
    @(negedge aclk);
    n_chk++;
    if ({m_tvalid, m_tlast, busy, done} !== 4'b0 || m_tdata !== 8'h00 ||
        pkt_count !== 8'h00) begin
      n_fail++;
      $display("FAIL rst_mid: v=%b l=%b b=%b d=%b data=%h cnt=%0d want all 0",
               m_tvalid, m_tlast, busy, done, m_tdata, pkt_count);
    end
    areset = 1'b0;
    run_burst("after_rst", 3, 1, 0, 8'h40, 0, 0);
  endtask

  task automatic test_zero_num();
    run_burst("num0", 2, 0, 1, 8'h55, 0, 0);
  endtask

  task automatic test_back_to_back();
    run_burst("b2b_a", 2, 2, 0, 8'h80, 0, 0);
    run_burst("b2b_b", 1, 2, 1, 8'h00, 2, 1);
  endtask

  task automatic test_random();
    for (int i = 0; i < 8; i++) begin
      run_burst("rand", int'($urandom_range(0, 5)), int'($urandom_range(1, 4)),
                int'($urandom_range(0, 3)), 8'($urandom), 2, 0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_packet();
    test_backpressure();
    test_gap_wrap();
    test_single_beat();
    test_reset_mid();
    test_zero_num();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
